// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: operand width, op codes, FSM states.
// No logic here; imported by the unit and its iterative core.
package mips_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV_ST = 2'd2
    } md_state_t;

endpackage

// File: rtl/mips_muldiv_core.sv
// Unsigned shift-add multiplier / restoring divider, one bit per step; load seeds operands.
// res_hi/res_lo are the combinational values the registers take on the next step (no backpressure).
module mips_muldiv_core #(
    parameter int XLEN = mips_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic [XLEN-1:0] res_hi,
    output logic [XLEN-1:0] res_lo
);
    import mips_pkg::*;

    // mul: r = running upper product, a = multiplier shifting out LSB-first, b = multiplicand
    // div: r = partial remainder, a = dividend shifting out / quotient shifting in, b = divisor
    logic [XLEN-1:0] r, a, b;
    logic            mode_div;

    logic [XLEN:0]   mul_add, mul_sum, shifted, diff;
    logic [XLEN-1:0] r_n, a_n;

    always_comb begin
        mul_add = a[0] ? {1'b0, b} : '0;
        mul_sum = {1'b0, r} + mul_add;
        shifted = {r, a[XLEN-1]};
        diff    = shifted - {1'b0, b};
        if (mode_div) begin
            if (!diff[XLEN]) begin
                r_n = diff[XLEN-1:0];
                a_n = {a[XLEN-2:0], 1'b1};
            end else begin
                r_n = shifted[XLEN-1:0];
                a_n = {a[XLEN-2:0], 1'b0};
            end
        end else begin
            r_n = mul_sum[XLEN:1];
            a_n = {mul_sum[0], a[XLEN-1:1]};
        end
    end

    assign res_hi = r_n;
    assign res_lo = a_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r        <= '0;
            a        <= '0;
            b        <= '0;
            mode_div <= 1'b0;
        end else if (load) begin
            r        <= '0;
            a        <= a_in;
            b        <= b_in;
            mode_div <= is_div;
        end else if (step) begin
            r <= r_n;
            a <= a_n;
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// MIPS HI/LO unit: MULT/MULTU/DIV/DIVU in ITER cycles (div-by-zero in 1), MTHI/MTLO in 1 cycle.
// Starts only accepted when idle; stall tells decode to hold start/MFxx while an op iterates.
module mips_muldiv_unit #(
    parameter int XLEN = mips_pkg::XLEN,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            mf_req,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            busy,
    output logic            done,
    output logic            stall,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    import mips_pkg::*;

    localparam int CW = $clog2(ITER) + 1;

    md_state_t         state;
    logic [CW-1:0]     counter;
    logic              neg_lo, neg_hi, dz_pend;
    logic [XLEN-1:0]   dz_val;

    logic              is_signed, is_mul, is_div, accept, last;
    logic              rs_neg, rt_neg;
    logic [XLEN-1:0]   rs_mag, rt_mag;
    logic [XLEN-1:0]   res_hi, res_lo, quo_s, rem_s;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        is_signed = (op == MD_MULT) || (op == MD_DIV);
        is_mul    = (op == MD_MULT) || (op == MD_MULTU);
        is_div    = (op == MD_DIV)  || (op == MD_DIVU);
        accept    = start && (state == MD_IDLE) &&
                    (is_mul || is_div || op == MD_MTHI || op == MD_MTLO);
        rs_neg    = is_signed && rs_val[XLEN-1];
        rt_neg    = is_signed && rt_val[XLEN-1];
        rs_mag    = rs_neg ? -rs_val : rs_val;
        rt_mag    = rt_neg ? -rt_val : rt_val;
        last      = (counter == CW'(ITER - 1));
        prod      = {res_hi, res_lo};
        prod_s    = neg_lo ? -prod : prod;
        quo_s     = neg_lo ? -res_lo : res_lo;
        rem_s     = neg_hi ? -res_hi : res_hi;
    end

    assign stall = busy && (start || mf_req);

    mips_muldiv_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (accept && (is_mul || is_div)),
        .step   (state != MD_IDLE),
        .is_div (is_div),
        .a_in   (rs_mag),
        .b_in   (rt_mag),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= MD_IDLE;
            counter     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            dz_pend     <= 1'b0;
            dz_val      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (accept) begin
                        div_by_zero <= 1'b0;
                        counter     <= '0;
                        neg_lo      <= rs_neg ^ rt_neg;
                        neg_hi      <= rs_neg;
                        dz_pend     <= is_div && (rt_val == '0);
                        dz_val      <= rs_val;
                        case (op)
                            MD_MTHI: hi <= rs_val;
                            MD_MTLO: lo <= rs_val;
                            MD_MULT, MD_MULTU: begin
                                state <= MD_MUL;
                                busy  <= 1'b1;
                            end
                            MD_DIV, MD_DIVU: begin
                                state <= MD_DIV_ST;
                                busy  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                MD_MUL: begin
                    counter <= counter + 1'b1;
                    if (last) begin
                        {hi, lo} <= prod_s;
                        state    <= MD_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                MD_DIV_ST: begin
                    counter <= counter + 1'b1;
                    // Zero divisor skips iteration: HI keeps the dividend, LO saturates.
                    if (dz_pend) begin
                        hi          <= dz_val;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                        state       <= MD_IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else if (last) begin
                        lo    <= quo_s;
                        hi    <= rem_s;
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
